// File: rtl/hazard_if.sv
// Signal bundle between the pipeline datapath and the hazard unit.
// The datapath side (master) drives pipeline status; the hazard unit (slave) returns enables and flushes.
interface hazard_if;
  logic        ihit;
  logic        dhit;
  logic [31:0] id_instr;
  logic        ex_dREN;
  logic [4:0]  ex_dest;
  logic        mem_dREN;
  logic        mem_dWEN;
  logic        mem_brtaken;
  logic        wb_halt;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        halted;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output ihit, dhit, id_instr, ex_dREN, ex_dest, mem_dREN, mem_dWEN, mem_brtaken, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, id_instr, ex_dREN, ex_dest, mem_dREN, mem_dWEN, mem_brtaken, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard control: data-memory wait, taken-branch flush, load-use stall,
// fetch miss, and halt, plus saturating stall and flush event counters.
module hazard_unit (
  input  logic CLK,
  input  logic RST,
  hazard_if.slave hz
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t state, state_next;

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       rt_read;
  logic       data_pending;
  logic       load_use;
  logic       flush_event;
  logic       stall_event;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush;

  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  assign opcode = hz.id_instr[31:26];
  assign rs     = hz.id_instr[25:21];
  assign rt     = hz.id_instr[20:16];

  // Only these opcodes actually read rt as a source; others write it or ignore it.
  always_comb begin
    unique case (opcode)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: rt_read = 1'b1;
      default:                         rt_read = 1'b0;
    endcase
  end

  assign data_pending = (hz.mem_dREN | hz.mem_dWEN) & ~hz.dhit;
  assign load_use     = hz.ex_dREN && (hz.ex_dest != 5'd0) &&
                        ((hz.ex_dest == rs) || ((hz.ex_dest == rt) && rt_read));

  // NOTE: every combinational output gets a default before the case; a missed branch would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;

    unique case (state)
      HALT: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end

      DWAIT: begin
        // The whole pipe freezes until memory answers; the answering cycle releases everything.
        if (hz.dhit) begin
          state_next = RUN;
        end else begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end
      end

      default: begin
        if (data_pending) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_en    = 1'b0;
          exmem_en   = 1'b0;
          memwb_en   = 1'b0;
          state_next = DWAIT;
        end else if (hz.mem_brtaken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID; the dependent instruction sees a bubble in EX for one cycle.
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (!hz.ihit) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end

        // Halt outranks everything for the next state, including entry into DWAIT.
        if (hz.wb_halt) begin
          state_next = HALT;
        end
      end
    endcase
  end

  assign flush_event = (state == RUN) && !data_pending && hz.mem_brtaken;
  assign stall_event = !pc_en && (state != HALT);

  // NOTE: state and counters use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_event && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush_event && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign hz.pc_en       = pc_en;
  assign hz.ifid_en     = ifid_en;
  assign hz.idex_en     = idex_en;
  assign hz.exmem_en    = exmem_en;
  assign hz.memwb_en    = memwb_en;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;
  assign hz.halted      = (state == HALT);
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by randomized traffic,
// all compared against a priority-rule reference model.
module tb_hazard_unit;

  logic clk;
  logic rst;

  hazard_if hz ();

  hazard_unit dut (
    .CLK (clk),
    .RST (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state: plain flags and counters.
  bit          m_halted;
  bit          m_waiting;
  logic [31:0] m_stall;
  logic [15:0] m_flush;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected {pc,ifid,idex,exmem,memwb, ifid_fl,idex_fl,exmem_fl} from the priority list.
  function automatic logic [7:0] model_ctl();
    logic [5:0] op;
    logic [4:0] rs_f, rt_f;
    bit pend, uses_rt, lu;
    op      = hz.id_instr[31:26];
    rs_f    = hz.id_instr[25:21];
    rt_f    = hz.id_instr[20:16];
    pend    = (hz.mem_dREN || hz.mem_dWEN) && !hz.dhit;
    uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    lu      = hz.ex_dREN && (hz.ex_dest != 0) &&
              ((hz.ex_dest == rs_f) || (uses_rt && hz.ex_dest == rt_f));
    if (m_halted)            return 8'b00000_000;
    if (m_waiting)           return hz.dhit ? 8'b11111_000 : 8'b00000_000;
    if (pend)                return 8'b00000_000;
    if (hz.mem_brtaken)      return 8'b11111_111;
    if (lu)                  return 8'b00111_010;
    if (!hz.ihit)            return 8'b01111_100;
    return 8'b11111_000;
  endfunction

  function automatic logic [7:0] dut_ctl();
    return {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
            hz.ifid_flush, hz.idex_flush, hz.exmem_flush};
  endfunction

  // Inputs are already applied at the falling edge; check, then advance the model across the rising edge.
  task automatic step();
    logic [7:0] exp_ctl;
    bit pend, brf;
    #1;
    exp_ctl = model_ctl();
    check("ctl",       {24'd0, dut_ctl()},   {24'd0, exp_ctl});
    check("halted",    {31'd0, hz.halted},   {31'd0, m_halted});
    check("stall_cnt", hz.stall_cnt,         m_stall);
    check("flush_cnt", {16'd0, hz.flush_cnt}, {16'd0, m_flush});
    pend = (hz.mem_dREN || hz.mem_dWEN) && !hz.dhit;
    brf  = !m_halted && !m_waiting && !pend && hz.mem_brtaken;
    @(posedge clk);
    if (!rst) begin
      if (!m_halted && !exp_ctl[7] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (brf && m_flush != 16'hFFFF) m_flush = m_flush + 1;
      if (!m_halted) begin
        if (m_waiting) begin
          if (hz.dhit) m_waiting = 0;
        end else if (hz.wb_halt) begin
          m_halted = 1;
        end else if (pend) begin
          m_waiting = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    hz.ihit        = 1'b1;
    hz.dhit        = 1'b0;
    hz.id_instr    = 32'h0000_0000;
    hz.ex_dREN     = 1'b0;
    hz.ex_dest     = 5'd0;
    hz.mem_dREN    = 1'b0;
    hz.mem_dWEN    = 1'b0;
    hz.mem_brtaken = 1'b0;
    hz.wb_halt     = 1'b0;
  endtask

  // Reset takes effect without a clock edge; outputs must look like RUN meanwhile.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_halted = 0; m_waiting = 0; m_stall = '0; m_flush = '0;
    check("rst_halted", {31'd0, hz.halted}, 32'd0);
    check("rst_stall",  hz.stall_cnt, 32'd0);
    check("rst_flush",  {16'd0, hz.flush_cnt}, 32'd0);
    check("rst_ctl",    {24'd0, dut_ctl()}, {24'd0, model_ctl()});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [6];
    ops = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08};
    return {ops[$urandom_range(5)], 5'($urandom_range(7)), 5'($urandom_range(7)), 16'($urandom)};
  endfunction

  initial begin
    rst = 1'b1;
    set_idle();
    m_halted = 0; m_waiting = 0; m_stall = '0; m_flush = '0;
    @(negedge clk);
    do_reset();

    // Load-use on rs of an ADDU: one-cycle stall.
    hz.ex_dREN  = 1'b1;
    hz.ex_dest  = 5'd5;
    hz.id_instr = {6'h00, 5'd5, 5'd6, 5'd7, 5'd0, 6'h21};
    step();
    hz.ex_dREN  = 1'b0;
    step();
    check("lu_stall_once", hz.stall_cnt, 32'd1);

    // Same with $zero as destination: no hazard.
    hz.ex_dREN  = 1'b1;
    hz.ex_dest  = 5'd0;
    hz.id_instr = {6'h00, 5'd0, 5'd6, 5'd7, 5'd0, 6'h21};
    step();
    set_idle();
    step();
    check("lu_zero_nostall", hz.stall_cnt, 32'd1);

    // Data miss: raised in RUN, three DWAIT cycles without dhit, then dhit.
    do_reset();
    hz.mem_dREN = 1'b1;
    for (int i = 0; i < 4; i++) step();
    hz.dhit = 1'b1;
    step();
    set_idle();
    step();
    check("dwait_stall", hz.stall_cnt, 32'd4);

    // Request satisfied the cycle it is raised: no wait state.
    hz.mem_dWEN = 1'b1;
    hz.dhit     = 1'b1;
    step();
    set_idle();
    step();

    // Taken branch overriding a load-use hazard.
    do_reset();
    hz.mem_brtaken = 1'b1;
    hz.ex_dREN     = 1'b1;
    hz.ex_dest     = 5'd9;
    hz.id_instr    = {6'h2B, 5'd1, 5'd9, 16'h0010};
    step();
    set_idle();
    step();
    check("br_flush_cnt", {16'd0, hz.flush_cnt}, 32'd1);

    // Halt: sticky, fetch activity ignored, left only by reset.
    hz.wb_halt = 1'b1;
    step();
    hz.wb_halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hz.ihit = i[0];
      step();
    end
    check("halt_sticky", {31'd0, hz.halted}, 32'd1);
    do_reset();
    set_idle();
    step();

    // Stall counter saturation.
    dut.stall_cnt_q = 32'hFFFF_FFFE;
    m_stall         = 32'hFFFF_FFFE;
    hz.ihit         = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("stall_sat", hz.stall_cnt, 32'hFFFF_FFFF);
    set_idle();
    step();

    // Randomized traffic; halts are eventually cleared with a reset.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      hz.ihit        = ($urandom_range(9) < 8);
      hz.dhit        = ($urandom_range(1) == 1);
      hz.id_instr    = rand_instr();
      hz.ex_dREN     = ($urandom_range(9) < 4);
      hz.ex_dest     = 5'($urandom_range(7));
      hz.mem_dREN    = ($urandom_range(9) == 0);
      hz.mem_dWEN    = ($urandom_range(9) == 0);
      hz.mem_brtaken = ($urandom_range(9) == 0);
      hz.wb_halt     = ($urandom_range(99) == 0);
      if ((m_halted && $urandom_range(7) == 0) || $urandom_range(299) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
